// File: rtl/lcd_read_port_if.sv
// Handshake between game logic and the LCD read port, plus the pin-mux grant
// that the top level feeds back when it hands the shared LCD pins over.
interface lcd_read_port_if;
    logic       iREQ;
    logic       iRS;
    logic       iPOLL;
    logic       iBUS_GNT;
    logic       oBUSY;
    logic       oVALID;
    logic [7:0] oDATA;
    logic       oTIMEOUT;
    logic       oBUS_REQ;

    modport master (
        output iREQ, iRS, iPOLL, iBUS_GNT,
        input  oBUSY, oVALID, oDATA, oTIMEOUT, oBUS_REQ
    );

    modport slave (
        input  iREQ, iRS, iPOLL, iBUS_GNT,
        output oBUSY, oVALID, oDATA, oTIMEOUT, oBUS_REQ
    );
endinterface

// File: rtl/lcd_read_port.sv
// Read-side HD44780 port: runs RW=1 cycles (busy flag/address or data) on the shared LCD
// pins and returns the sampled byte through request/valid, optionally polling BF until ready.
module lcd_read_port #(
    parameter int T_SETUP   = 3,
    parameter int T_EHIGH   = 15,
    parameter int T_HOLD    = 2,
    parameter int T_RECOVER = 10,
    parameter int MAX_POLLS = 255
) (
    input  logic           iCLK_50MHZ,
    input  logic           iRST_N,
    lcd_read_port_if.slave bus,
    output logic           LCD_RW,
    output logic           LCD_E,
    output logic           LCD_RS,
    inout  wire  [7:0]     DATA_BUS
);

    localparam int SETUP_N   = (T_SETUP   < 1) ? 1 : T_SETUP;
    localparam int EHIGH_N   = (T_EHIGH   < 1) ? 1 : T_EHIGH;
    localparam int HOLD_N    = (T_HOLD    < 1) ? 1 : T_HOLD;
    localparam int RECOVER_N = (T_RECOVER < 1) ? 1 : T_RECOVER;
    localparam int POLL_N    = (MAX_POLLS < 1) ? 1 : ((MAX_POLLS > 255) ? 255 : MAX_POLLS);
    localparam int MAX_A     = (SETUP_N > EHIGH_N) ? SETUP_N : EHIGH_N;
    localparam int MAX_B     = (HOLD_N > RECOVER_N) ? HOLD_N : RECOVER_N;
    localparam int MAX_N     = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW        = ($clog2(MAX_N) < 5) ? 5 : $clog2(MAX_N);

    // Each timed state loads N-1 on entry and leaves when the counter reaches zero.
    localparam logic [TW-1:0] SETUP_LD   = TW'(SETUP_N - 1);
    localparam logic [TW-1:0] EHIGH_LD   = TW'(EHIGH_N - 1);
    localparam logic [TW-1:0] HOLD_LD    = TW'(HOLD_N - 1);
    localparam logic [TW-1:0] RECOVER_LD = TW'(RECOVER_N - 1);
    localparam logic [8:0]    POLL_LIMIT = 9'(POLL_N);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GNT,
        SETUP,
        EHIGH,
        HOLD,
        RECOVER,
        DONE
    } state_t;

    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic          rsSel_q;
    logic          pollMode_q;
    logic [7:0]    pollCnt_q;
    logic [7:0]    sample_q;
    logic [7:0]    data_q;
    logic          busy_q;
    logic          valid_q;
    logic          timeout_q;
    logic          busReq_q;
    logic          lcdRw_q;
    logic          lcdE_q;
    logic          lcdRs_q;

    logic          timerDone_d;
    logic [8:0]    pollNext_d;

    assign timerDone_d = (timer_q == '0);
    assign pollNext_d  = {1'b0, pollCnt_q} + 9'd1;

    // The data bus belongs to the LCD during reads; this block only ever listens.
    assign DATA_BUS = 8'bzzzz_zzzz;

    assign bus.oBUSY    = busy_q;
    assign bus.oVALID   = valid_q;
    assign bus.oDATA    = data_q;
    assign bus.oTIMEOUT = timeout_q;
    assign bus.oBUS_REQ = busReq_q;
    assign LCD_RW       = lcdRw_q;
    assign LCD_E        = lcdE_q;
    assign LCD_RS       = lcdRs_q;

    always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            rsSel_q    <= 1'b0;
            pollMode_q <= 1'b0;
            pollCnt_q  <= 8'h00;
            sample_q   <= 8'h00;
            data_q     <= 8'h00;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            busReq_q   <= 1'b0;
            lcdRw_q    <= 1'b0;
            lcdE_q     <= 1'b0;
            lcdRs_q    <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.iREQ) begin
                        rsSel_q    <= bus.iRS;
                        pollMode_q <= bus.iPOLL & ~bus.iRS;
                        busy_q     <= 1'b1;
                        busReq_q   <= 1'b1;
                        state_q    <= WAIT_GNT;
                    end
                end
                WAIT_GNT: begin
                    if (bus.iBUS_GNT) begin
                        lcdRw_q <= 1'b1;
                        lcdRs_q <= rsSel_q;
                        timer_q <= SETUP_LD;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (timerDone_d) begin
                        lcdE_q  <= 1'b1;
                        timer_q <= EHIGH_LD;
                        state_q <= EHIGH;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                EHIGH: begin
                    if (timerDone_d) begin
                        sample_q <= DATA_BUS;
                        lcdE_q   <= 1'b0;
                        timer_q  <= HOLD_LD;
                        state_q  <= HOLD;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                HOLD: begin
                    // A still-busy LCD in poll mode earns another read unless the limit is reached.
                    if (timerDone_d) begin
                        if (pollMode_q && sample_q[7] && (pollNext_d < POLL_LIMIT)) begin
                            pollCnt_q <= pollNext_d[7:0];
                            timer_q   <= RECOVER_LD;
                            state_q   <= RECOVER;
                        end else begin
                            data_q    <= sample_q;
                            valid_q   <= 1'b1;
                            timeout_q <= pollMode_q & sample_q[7];
                            state_q   <= DONE;
                        end
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                RECOVER: begin
                    if (timerDone_d) begin
                        timer_q <= SETUP_LD;
                        state_q <= SETUP;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                DONE: begin
                    busy_q     <= 1'b0;
                    busReq_q   <= 1'b0;
                    lcdRw_q    <= 1'b0;
                    lcdRs_q    <= 1'b0;
                    pollCnt_q  <= 8'h00;
                    pollMode_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lcd_read_port.md
Name: lcd_read_port

Overview:
- Read-side companion to the HD44780-style 16x2 LCD writer (LCD_Display). Performs LCD read cycles with RW=1:
  - busy-flag/address-counter read (RS=0);
  - DDRAM/CGRAM data read (RS=1).
- Returns the sampled byte to game logic through a request/valid handshake.
- Optional busy-poll mode repeats BF reads until the LCD is ready, so the writer can wait on the real busy flag instead of fixed delays.
- Sits between the top-level game module and the shared LCD pins. The top level muxes LCD_RW/LCD_E/LCD_RS using oBUS_REQ/iBUS_GNT.

Parameters:
- T_SETUP, 3, clocks from RS/RW valid to E rise (tAS >= 40 ns at 50 MHz).
- T_EHIGH, 15, clocks E held high; DATA_BUS sampled on the last of them (PWEH >= 230 ns, tDDR <= 160 ns).
- T_HOLD, 2, clocks RS/RW held after E fall (tAH).
- T_RECOVER, 10, clocks E held low before the next E rise (E cycle >= 500 ns).
- MAX_POLLS, 255, BF reads before poll mode gives up (range 1..255).

Ports:
- iCLK_50MHZ  input  1  system clock, 50 MHz.
- iRST_N  input  1  asynchronous active-low reset.
- iREQ  input  1  start request; accepted only in IDLE.
- iRS  input  1  0 = busy/address read, 1 = data read; captured at accept.
- iPOLL  input  1  1 = repeat BF reads until BF=0; ignored when iRS=1; captured at accept.
- oBUSY  output  1  high from accept until return to IDLE.
- oVALID  output  1  one-clock pulse; oDATA valid in that cycle.
- oDATA  output  8  last sampled byte; held until the next sample.
- oTIMEOUT  output  1  one-clock pulse, coincident with oVALID, when the poll limit is hit.
- oBUS_REQ  output  1  high while a transaction is pending or active.
- iBUS_GNT  input  1  pin-mux grant from the top level.
- LCD_RW  output  1  read/write select; 1 while granted and active, else 0.
- LCD_E  output  1  enable strobe.
- LCD_RS  output  1  register select.
- DATA_BUS  inout  8  never driven by this block (constant high-Z); sampled only.

Behaviour:
- Reset (async, iRST_N=0):
  - State = IDLE.
  - oBUSY, oVALID, oTIMEOUT, oBUS_REQ, LCD_E, LCD_RW, LCD_RS = 0; oDATA = 8'h00; poll counter = 0.
  - Mid-transaction reset drops LCD_E in the same cycle, with no completion pulse.
- States: IDLE, WAIT_GNT, SETUP, EHIGH, HOLD, RECOVER, DONE.
- IDLE:
  - iREQ=1 captures iRS and iPOLL&~iRS, sets oBUSY and oBUS_REQ, then goes to WAIT_GNT.
  - iREQ while oBUSY=1 is ignored; no queueing.
- WAIT_GNT:
  - Wait for iBUS_GNT=1, then go to SETUP.
  - LCD pins stay 0 until the grant.
- SETUP: LCD_RW=1, LCD_RS=captured RS, LCD_E=0, for T_SETUP clocks.
- EHIGH:
  - LCD_E=1 for T_EHIGH clocks.
  - DATA_BUS is registered into a sample register on the final EHIGH clock.
- HOLD: LCD_E=0, RS/RW held for T_HOLD clocks.
- Leaving HOLD:
  - Non-poll mode, or poll mode with sample[7]=0: go to DONE.
  - Poll mode with sample[7]=1 and poll counter+1 < MAX_POLLS: increment the counter, go to RECOVER, then back to SETUP.
  - Poll mode with sample[7]=1 and the counter at its limit: set the timeout flag, go to DONE.
- RECOVER: LCD_E=0, LCD_RW=1 held, for T_RECOVER clocks.
- DONE (one clock):
  - oDATA = sample; oVALID=1; oTIMEOUT = flag.
  - oBUSY, oBUS_REQ and LCD_RW drop in the next cycle; return to IDLE; counter and flag cleared.
- Bus grant:
  - Loss of iBUS_GNT after SETUP is a top-level protocol error; the block ignores it and completes the cycle.
  - Grant must stay high while oBUS_REQ=1.
- Latency, request to oVALID, single read with immediate grant: 1 + T_SETUP + T_EHIGH + T_HOLD + 1 clocks = 22 with defaults.
- Each extra poll iteration adds T_RECOVER + T_SETUP + T_EHIGH + T_HOLD = 30 clocks.
- Timers: one down-counter, 5 bits minimum, reloaded on every state entry. Parameters of 0 are treated as 1.

Test Plan:
- Reset released, iREQ with iRS=1, grant tied high, DATA_BUS=8'h4D -> LCD_E high for exactly 15 clocks; oVALID pulses 22 clocks after accept with oDATA=8'h4D; oTIMEOUT=0; LCD_RW back to 0 afterwards.
- iREQ with iRS=0, iPOLL=1; model returns BF=1 for 3 reads then 8'h05 -> exactly 4 E pulses, each separated by >= 10 low clocks; oDATA=8'h05; oTIMEOUT=0.
- Poll mode with BF stuck at 1, MAX_POLLS=4 -> exactly 4 E pulses; oVALID and oTIMEOUT pulse together; oDATA[7]=1.
- iREQ with iBUS_GNT held 0 for 50 clocks -> oBUS_REQ=1 and LCD_E/LCD_RW=0 throughout; the cycle starts the clock after the grant.
- iRST_N asserted during EHIGH -> LCD_E, LCD_RW and oBUSY = 0 immediately; no oVALID; a new iREQ after reset completes normally.
- Second iREQ pulsed while oBUSY=1 -> ignored; exactly one oVALID; DATA_BUS is never driven (checked for Z throughout).
